// File: rtl/frame_store_pkg.sv
// rtl/frame_store_pkg.sv - shared types and constants for the frame-store responder
package frame_store_pkg;

  localparam int DE_ADDR_W = 18;
  localparam int DE_DATA_W = 32;
  localparam int DE_LANES  = 4;

  // All byte enables inactive: a write that touches no lane.
  localparam logic [DE_LANES-1:0] NBYTE_NONE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RD_WAIT
  } state_t;

endpackage

// File: rtl/frame_store_merge.sv
// rtl/frame_store_merge.sv - combinational byte-lane merge into the write-combining buffer
module frame_store_merge
  import frame_store_pkg::*;
(
  input  logic [DE_DATA_W-1:0] buf_data,
  input  logic [DE_LANES-1:0]  buf_be_n,
  input  logic [DE_DATA_W-1:0] de_w_data,
  input  logic [DE_LANES-1:0]  de_nbyte,
  output logic [DE_DATA_W-1:0] merged_data,
  output logic [DE_LANES-1:0]  merged_be_n
);

  // Each enabled lane replaces the buffered byte and is marked as written.
  always_comb begin
    merged_data = buf_data;
    merged_be_n = buf_be_n;
    for (int i = 0; i < DE_LANES; i++) begin
      if (!de_nbyte[i]) begin
        merged_data[8*i +: 8] = de_w_data[8*i +: 8];
        merged_be_n[i]        = 1'b0;
      end
    end
  end

endmodule

// File: rtl/frame_store_responder.sv
// rtl/frame_store_responder.sv - drawing-engine frame-store responder with one-entry write combining
module frame_store_responder
  import frame_store_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 de_req,
  output logic                 de_ack,
  input  logic [DE_ADDR_W-1:0] de_addr,
  input  logic [DE_LANES-1:0]  de_nbyte,
  input  logic                 de_rnw,
  input  logic [DE_DATA_W-1:0] de_w_data,
  output logic [DE_DATA_W-1:0] de_r_data,
  output logic                 dirty,
  output logic [DE_ADDR_W-1:0] sram_addr,
  output logic [DE_DATA_W-1:0] sram_wdata,
  output logic [DE_LANES-1:0]  sram_be_n,
  output logic                 sram_we,
  output logic                 sram_re,
  input  logic [DE_DATA_W-1:0] sram_rdata
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);

  state_t state, state_next;

  logic                 buf_valid;
  logic [DE_ADDR_W-1:0] buf_addr;
  logic [DE_DATA_W-1:0] buf_data;
  logic [DE_LANES-1:0]  buf_be_n;
  logic [CNT_W-1:0]     cnt;

  logic [DE_DATA_W-1:0] merged_data;
  logic [DE_LANES-1:0]  merged_be_n;

  logic go_flush;
  logic go_read;
  logic take_write;
  logic read_done;

  assign dirty = buf_valid;

  frame_store_merge u_merge (
    .buf_data    (buf_data),
    .buf_be_n    (buf_be_n),
    .de_w_data   (de_w_data),
    .de_nbyte    (de_nbyte),
    .merged_data (merged_data),
    .merged_be_n (merged_be_n)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode; the ack cycle is a dead cycle so a held request is taken once.
  always_comb begin
    state_next = state;
    go_flush   = 1'b0;
    go_read    = 1'b0;
    take_write = 1'b0;
    read_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (de_ack) begin
          state_next = ST_IDLE;
        end else if (de_req) begin
          if (de_rnw) begin
            if (buf_valid) begin
              go_flush   = 1'b1;
              state_next = ST_FLUSH;
            end else begin
              go_read    = 1'b1;
              state_next = ST_RD_WAIT;
            end
          end else if (!buf_valid || de_addr == buf_addr) begin
            take_write = 1'b1;
          end else begin
            go_flush   = 1'b1;
            state_next = ST_FLUSH;
          end
        end else if (buf_valid) begin
          go_flush   = 1'b1;
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: state_next = ST_IDLE;
      ST_RD_WAIT: begin
        if (cnt == '0) begin
          read_done  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: buffer, SRAM command registers, latency counter and read return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid  <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      buf_be_n   <= NBYTE_NONE;
      cnt        <= '0;
      de_ack     <= 1'b0;
      de_r_data  <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_be_n  <= NBYTE_NONE;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
    end else begin
      de_ack  <= take_write | read_done;
      sram_we <= go_flush;
      sram_re <= go_read;

      if (go_flush) begin
        sram_addr  <= buf_addr;
        sram_wdata <= buf_data;
        sram_be_n  <= buf_be_n;
      end

      if (go_read) begin
        sram_addr <= de_addr;
        cnt       <= CNT_LOAD;
      end else if (state == ST_RD_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (state == ST_FLUSH) begin
        buf_valid <= 1'b0;
        buf_be_n  <= NBYTE_NONE;
      end

      // A write with no enabled lane is acknowledged but leaves the buffer alone.
      if (take_write && de_nbyte != NBYTE_NONE) begin
        buf_valid <= 1'b1;
        buf_addr  <= de_addr;
        buf_data  <= merged_data;
        buf_be_n  <= merged_be_n;
      end

      if (read_done) de_r_data <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_frame_store_responder.sv
// tb/tb_frame_store_responder.sv - randomized self-checking bench for frame_store_responder
module tb_frame_store_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de_req    [3];
  logic        de_rnw    [3];
  logic [17:0] de_addr   [3];
  logic [3:0]  de_nbyte  [3];
  logic [31:0] de_w_data [3];
  logic        de_ack    [3];
  logic [31:0] de_r_data [3];
  logic        dirty     [3];
  logic [17:0] sram_addr [3];
  logic [31:0] sram_wdata[3];
  logic [3:0]  sram_be_n [3];
  logic        sram_we   [3];
  logic        sram_re   [3];
  logic [31:0] sram_rdata[3];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    frame_store_responder #(.RD_LAT(g == 0 ? 2 : (g == 1 ? 1 : 4))) u_dut (
      .clk        (clk),
      .rst        (rst),
      .de_req     (de_req[g]),
      .de_ack     (de_ack[g]),
      .de_addr    (de_addr[g]),
      .de_nbyte   (de_nbyte[g]),
      .de_rnw     (de_rnw[g]),
      .de_w_data  (de_w_data[g]),
      .de_r_data  (de_r_data[g]),
      .dirty      (dirty[g]),
      .sram_addr  (sram_addr[g]),
      .sram_wdata (sram_wdata[g]),
      .sram_be_n  (sram_be_n[g]),
      .sram_we    (sram_we[g]),
      .sram_re    (sram_re[g]),
      .sram_rdata (sram_rdata[g])
    );
  end

  // SRAM models: masked writes, reads return exactly RD_LAT cycles after the strobe, X otherwise.
  logic [31:0] mem [int];
  logic [31:0] pipe [3][4];

  always @(posedge clk) begin
    int key;
    logic [31:0] w;
    for (int k = 0; k < 3; k++) begin
      key = k * 262144 + int'(sram_addr[k]);
      if (sram_we[k] === 1'b1) begin
        w = mem.exists(key) ? mem[key] : 32'h0;
        for (int j = 0; j < 4; j++)
          if (!sram_be_n[k][j]) w[8*j +: 8] = sram_wdata[k][8*j +: 8];
        mem[key] = w;
      end
      for (int i = 3; i > 0; i--) pipe[k][i] <= pipe[k][i-1];
      if (sram_re[k] === 1'b1) pipe[k][0] <= mem.exists(key) ? mem[key] : 32'h0;
      else                     pipe[k][0] <= 32'hx;
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) sram_rdata[k] = pipe[k][lat_of(k) - 1];
  end

  // Strobe monitor, sampled mid-cycle.
  int          cyc = 0;
  int          we_cnt  [3] = '{0, 0, 0};
  int          we_cyc  [3] = '{0, 0, 0};
  int          re_cyc  [3] = '{0, 0, 0};
  logic [17:0] we_addr [3];
  logic [31:0] we_data [3];
  logic [3:0]  we_be_n [3];
  int          both_cnt = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (sram_we[k] === 1'b1) begin
        we_cnt[k]  = we_cnt[k] + 1;
        we_cyc[k]  = cyc;
        we_addr[k] = sram_addr[k];
        we_data[k] = sram_wdata[k];
        we_be_n[k] = sram_be_n[k];
      end
      if (sram_re[k] === 1'b1) re_cyc[k] = cyc;
      if (sram_we[k] === 1'b1 && sram_re[k] === 1'b1) both_cnt = both_cnt + 1;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      de_req[d] = 1'b0; de_rnw[d] = 1'b0; de_addr[d] = '0;
      de_nbyte[d] = 4'hF; de_w_data[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // One transfer; lat is the cycle (counted from the first request cycle) in which de_ack is seen, -1 on timeout.
  task automatic xfer(input int d, input logic rnw, input logic [17:0] a,
                      input logic [3:0] nb, input logic [31:0] wd, output int lat);
    @(posedge clk); #1;
    de_req[d] = 1'b1; de_rnw[d] = rnw; de_addr[d] = a; de_nbyte[d] = nb; de_w_data[d] = wd;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (de_ack[d] === 1'b1) begin lat = n; break; end
    end
  endtask

  task automatic go_idle(input int d, input int n);
    @(posedge clk); #1;
    de_req[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (de_ack[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_ack got %b want 0", de_ack[0]); end
    tests_run++; if (dirty[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_dirty got %b want 0", dirty[0]); end
    tests_run++; if (sram_we[0] !== 1'b0 || sram_re[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_strobes got we=%b re=%b want 0 0", sram_we[0], sram_re[0]); end
    tests_run++; if (sram_be_n[0] !== 4'hF || sram_addr[0] !== 18'h0 || sram_wdata[0] !== 32'h0) begin tests_failed++; $display("FAIL reset_sram_fields got be_n=%h addr=%h wdata=%h want f 0 0", sram_be_n[0], sram_addr[0], sram_wdata[0]); end
    tests_run++; if (de_r_data[0] !== 32'h0) begin tests_failed++; $display("FAIL reset_r_data got %h want 0", de_r_data[0]); end
  endtask

  task automatic test_row_merge();
    int lat;
    int base;
    logic [3:0]  nbs [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [31:0] wds [4] = '{{4{8'h11}}, {4{8'h22}}, {4{8'h33}}, {4{8'h44}}};
    do_reset();
    base = we_cnt[0];
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b0, 18'h0, nbs[i], wds[i], lat);
      tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL row_merge_ack%0d got latency %0d want 1", i, lat); end
    end
    tests_run++; if (dirty[0] !== 1'b1) begin tests_failed++; $display("FAIL row_merge_dirty got %b want 1", dirty[0]); end
    @(posedge clk); #1; de_req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (sram_we[0] !== 1'b1 || dirty[0] !== 1'b1) begin tests_failed++; $display("FAIL row_merge_drain_flush got we=%b dirty=%b want 1 1", sram_we[0], dirty[0]); end
    @(negedge clk);
    tests_run++; if (dirty[0] !== 1'b0) begin tests_failed++; $display("FAIL row_merge_dirty_fall got %b want 0", dirty[0]); end
    repeat (3) @(negedge clk);
    tests_run++; if (we_cnt[0] - base !== 1) begin tests_failed++; $display("FAIL row_merge_we_count got %0d want 1", we_cnt[0] - base); end
    tests_run++; if (we_data[0] !== 32'h44332211 || we_be_n[0] !== 4'b0000 || we_addr[0] !== 18'h0) begin tests_failed++; $display("FAIL row_merge_flush got addr=%h data=%h be_n=%b want 0 44332211 0000", we_addr[0], we_data[0], we_be_n[0]); end
  endtask

  task automatic test_miss_flush();
    int lat;
    int base;
    do_reset();
    base = we_cnt[0];
    xfer(0, 1'b0, 18'h00001, 4'b1110, 32'h000000AA, lat);
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL miss_first_ack got latency %0d want 1", lat); end
    xfer(0, 1'b0, 18'h000A0, 4'b1101, 32'h0000BB00, lat);
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL miss_second_ack got latency %0d want 3", lat); end
    tests_run++; if (we_cnt[0] - base !== 1 || we_addr[0] !== 18'h1 || we_be_n[0] !== 4'b1110 || we_data[0][7:0] !== 8'hAA) begin tests_failed++; $display("FAIL miss_flush_cmd got n=%0d addr=%h be_n=%b byte0=%h want 1 1 1110 aa", we_cnt[0] - base, we_addr[0], we_be_n[0], we_data[0][7:0]); end
    go_idle(0, 4);
  endtask

  task automatic test_read_after_write();
    int lat;
    do_reset();
    mem[32'h10] = 32'hDEADBEEF;
    xfer(0, 1'b0, 18'h00010, 4'b1110, 32'h00000077, lat);
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL raw_write_ack got latency %0d want 1", lat); end
    xfer(0, 1'b1, 18'h00010, 4'hF, 32'h0, lat);
    tests_run++; if (lat !== 6) begin tests_failed++; $display("FAIL raw_read_ack got latency %0d want 6", lat); end
    tests_run++; if (de_r_data[0] !== 32'hDEADBE77) begin tests_failed++; $display("FAIL raw_read_data got %h want deadbe77", de_r_data[0]); end
    tests_run++; if (!(we_cyc[0] < re_cyc[0])) begin tests_failed++; $display("FAIL raw_order got we_cycle=%0d re_cycle=%0d want we before re", we_cyc[0], re_cyc[0]); end
    go_idle(0, 2);
  endtask

  task automatic test_no_lane();
    int lat;
    int base;
    do_reset();
    base = we_cnt[0];
    xfer(0, 1'b0, 18'h00055, 4'b1111, 32'hFFFFFFFF, lat);
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL nolane_ack got latency %0d want 1", lat); end
    tests_run++; if (dirty[0] !== 1'b0) begin tests_failed++; $display("FAIL nolane_dirty got %b want 0", dirty[0]); end
    go_idle(0, 4);
    tests_run++; if (we_cnt[0] - base !== 0) begin tests_failed++; $display("FAIL nolane_we got %0d writes want 0", we_cnt[0] - base); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int acks;
    do_reset();
    @(posedge clk); #1;
    de_req[0] = 1'b1; de_rnw[0] = 1'b1; de_addr[0] = 18'h00033;
    repeat (3) @(negedge clk);
    rst = 1'b1; de_req[0] = 1'b0;
    #1;
    tests_run++; if (de_ack[0] !== 1'b0 || sram_re[0] !== 1'b0 || sram_we[0] !== 1'b0 || dirty[0] !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ctrl got ack=%b re=%b we=%b dirty=%b want 0 0 0 0", de_ack[0], sram_re[0], sram_we[0], dirty[0]); end
    tests_run++; if (sram_addr[0] !== 18'h0 || sram_be_n[0] !== 4'hF || de_r_data[0] !== 32'h0) begin tests_failed++; $display("FAIL rstmid_fields got addr=%h be_n=%h r_data=%h want 0 f 0", sram_addr[0], sram_be_n[0], de_r_data[0]); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (6) begin @(negedge clk); if (de_ack[0] === 1'b1) acks++; end
    tests_run++; if (acks !== 0) begin tests_failed++; $display("FAIL rstmid_noack got %0d acks want 0", acks); end
    mem[0] = 32'h0BADF00D;
    xfer(0, 1'b1, 18'h0, 4'hF, 32'h0, lat);
    tests_run++; if (lat !== 4 || de_r_data[0] !== 32'h0BADF00D) begin tests_failed++; $display("FAIL rstmid_read got latency %0d data %h want 4 0badf00d", lat, de_r_data[0]); end
    go_idle(0, 2);
  endtask

  task automatic test_latency_sweep();
    int lat;
    for (int d = 1; d < 3; d++) begin
      mem[d * 262144 + 5] = 32'hC0DE0000 + d;
      xfer(d, 1'b1, 18'h00005, 4'hF, 32'h0, lat);
      tests_run++; if (lat !== lat_of(d) + 2) begin tests_failed++; $display("FAIL sweep_lat%0d got latency %0d want %0d", lat_of(d), lat, lat_of(d) + 2); end
      tests_run++; if (de_r_data[d] !== 32'hC0DE0000 + d) begin tests_failed++; $display("FAIL sweep_data%0d got %h want %h", lat_of(d), de_r_data[d], 32'hC0DE0000 + d); end
      go_idle(d, 2);
    end
  endtask

  // Reference: the buffer is invisible to data (plain byte-addressed memory); timing follows
  // the responder rules from the buffered address alone.
  task automatic test_random();
    logic [31:0] ref_mem [int];
    logic        bvalid;
    logic [17:0] baddr;
    logic [17:0] a;
    logic [3:0]  nb;
    logic [31:0] wd;
    logic [31:0] want;
    logic        rnw;
    int          lat;
    int          want_lat;
    do_reset();
    bvalid = 1'b0;
    baddr  = '0;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        go_idle(0, 3);
        bvalid = 1'b0;
        tests_run++; if (dirty[0] !== 1'b0) begin tests_failed++; $display("FAIL rand_drain%0d got dirty %b want 0", t, dirty[0]); end
      end
      a   = 18'h00200 + 18'($urandom_range(0, 2));
      rnw = ($urandom_range(0, 2) == 0);
      nb  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      if (rnw) begin
        want_lat = bvalid ? 4 + lat_of(0) : 2 + lat_of(0);
        bvalid   = 1'b0;
        want     = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
      end else begin
        want_lat = (!bvalid || a == baddr) ? 1 : 3;
        if (want_lat == 3) bvalid = 1'b0;
        if (nb != 4'hF) begin bvalid = 1'b1; baddr = a; end
        want = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
        for (int j = 0; j < 4; j++) if (!nb[j]) want[8*j +: 8] = wd[8*j +: 8];
        ref_mem[int'(a)] = want;
      end
      xfer(0, rnw, a, nb, wd, lat);
      tests_run++; if (lat !== want_lat) begin tests_failed++; $display("FAIL rand_lat%0d rnw=%b addr=%h got %0d want %0d", t, rnw, a, lat, want_lat); end
      if (rnw) begin
        tests_run++; if (de_r_data[0] !== want) begin tests_failed++; $display("FAIL rand_data%0d addr=%h got %h want %h", t, a, de_r_data[0], want); end
      end
    end
    go_idle(0, 4);
  endtask

  task automatic test_exclusive();
    tests_run++; if (both_cnt !== 0) begin tests_failed++; $display("FAIL we_re_exclusive got %0d overlapping cycles want 0", both_cnt); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_row_merge();
    test_miss_flush();
    test_read_after_write();
    test_no_lane();
    test_reset_mid();
    test_latency_sweep();
    test_random();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
